// File: rtl/inst_predecoder_pkg.sv
// Shared core definitions: RV32I major opcodes, compact controller opcodes,
// compact ALU codes and the decoded-entry layout buffered by the predecoder.
package inst_predecoder_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [6:0] CO_ALU_R   = 7'd0;
  localparam logic [6:0] CO_LW      = 7'd1;
  localparam logic [6:0] CO_ADDI    = 7'd2;
  localparam logic [6:0] CO_XORI    = 7'd3;
  localparam logic [6:0] CO_ORI     = 7'd4;
  localparam logic [6:0] CO_SLTI    = 7'd5;
  localparam logic [6:0] CO_JALR    = 7'd6;
  localparam logic [6:0] CO_SW      = 7'd7;
  localparam logic [6:0] CO_JAL     = 7'd8;
  localparam logic [6:0] CO_BEQ     = 7'd9;
  localparam logic [6:0] CO_BNE     = 7'd10;
  localparam logic [6:0] CO_BLT     = 7'd11;
  localparam logic [6:0] CO_BGE     = 7'd12;
  localparam logic [6:0] CO_LUI     = 7'd13;
  localparam logic [6:0] CO_ILLEGAL = 7'h7F;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] instr;
    logic        illegal;
  } dec_entry_t;

  function automatic dec_entry_t make_entry(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [31:0] instr, input logic illegal);
    dec_entry_t e;
    e.op      = op;
    e.f3      = f3;
    e.instr   = instr;
    e.illegal = illegal;
    return e;
  endfunction

endpackage

// File: rtl/inst_predecoder_rv_op_mapper.sv
// Purely combinational RV32I opcode/funct mapping onto the compact controller
// opcode and ALU function code; anything unsupported maps to the illegal code.
module rv_op_mapper
  import inst_predecoder_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [6:0] op_o,
  output logic [2:0] f3_o,
  output logic       illegal_o
);

  // Opcode/funct decode; defaults describe the illegal encoding
  always_comb begin
    op_o      = CO_ILLEGAL;
    f3_o      = 3'b000;
    illegal_o = 1'b1;
    case (opcode_i)
      OPC_OP: begin
        if (funct7_i == F7_BASE) begin
          case (funct3_i)
            3'b000:  begin op_o = CO_ALU_R; f3_o = ALU_ADD; illegal_o = 1'b0; end
            3'b111:  begin op_o = CO_ALU_R; f3_o = ALU_AND; illegal_o = 1'b0; end
            3'b110:  begin op_o = CO_ALU_R; f3_o = ALU_OR;  illegal_o = 1'b0; end
            3'b010:  begin op_o = CO_ALU_R; f3_o = ALU_SLT; illegal_o = 1'b0; end
            3'b100:  begin op_o = CO_ALU_R; f3_o = ALU_XOR; illegal_o = 1'b0; end
            default: begin op_o = CO_ILLEGAL; f3_o = 3'b000; illegal_o = 1'b1; end
          endcase
        end else if ((funct7_i == F7_ALT) && (funct3_i == 3'b000)) begin
          op_o = CO_ALU_R; f3_o = ALU_SUB; illegal_o = 1'b0;
        end else begin
          op_o = CO_ILLEGAL; f3_o = 3'b000; illegal_o = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (funct3_i == 3'b010) begin
          op_o = CO_LW; f3_o = funct3_i; illegal_o = 1'b0;
        end else begin
          op_o = CO_ILLEGAL; f3_o = 3'b000; illegal_o = 1'b1;
        end
      end
      OPC_OPIMM: begin
        case (funct3_i)
          3'b000:  begin op_o = CO_ADDI; f3_o = funct3_i; illegal_o = 1'b0; end
          3'b100:  begin op_o = CO_XORI; f3_o = funct3_i; illegal_o = 1'b0; end
          3'b110:  begin op_o = CO_ORI;  f3_o = funct3_i; illegal_o = 1'b0; end
          3'b010:  begin op_o = CO_SLTI; f3_o = funct3_i; illegal_o = 1'b0; end
          default: begin op_o = CO_ILLEGAL; f3_o = 3'b000; illegal_o = 1'b1; end
        endcase
      end
      OPC_JALR: begin
        op_o = CO_JALR; f3_o = funct3_i; illegal_o = 1'b0;
      end
      OPC_STORE: begin
        if (funct3_i == 3'b010) begin
          op_o = CO_SW; f3_o = funct3_i; illegal_o = 1'b0;
        end else begin
          op_o = CO_ILLEGAL; f3_o = 3'b000; illegal_o = 1'b1;
        end
      end
      OPC_JAL: begin
        op_o = CO_JAL; f3_o = funct3_i; illegal_o = 1'b0;
      end
      OPC_BRANCH: begin
        case (funct3_i)
          3'b000:  begin op_o = CO_BEQ; f3_o = funct3_i; illegal_o = 1'b0; end
          3'b001:  begin op_o = CO_BNE; f3_o = funct3_i; illegal_o = 1'b0; end
          3'b100:  begin op_o = CO_BLT; f3_o = funct3_i; illegal_o = 1'b0; end
          3'b101:  begin op_o = CO_BGE; f3_o = funct3_i; illegal_o = 1'b0; end
          default: begin op_o = CO_ILLEGAL; f3_o = 3'b000; illegal_o = 1'b1; end
        endcase
      end
      OPC_LUI: begin
        op_o = CO_LUI; f3_o = funct3_i; illegal_o = 1'b0;
      end
      default: begin
        op_o = CO_ILLEGAL; f3_o = 3'b000; illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_predecoder.sv
// Instruction predecoder: decodes raw RV32I words on entry and buffers the
// decoded entries in a DEPTH-deep FIFO feeding the core controller.
module inst_predecoder
  import inst_predecoder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_op,
  output logic [2:0]  out_f3,
  output logic [31:0] out_instr,
  output logic        out_illegal,
  output logic [7:0]  illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       ill_cnt_q, ill_cnt_d;
  dec_entry_t       mem_q [DEPTH];

  logic [6:0]  map_op_s;
  logic [2:0]  map_f3_s;
  logic        map_ill_s;
  dec_entry_t  in_entry_s;
  dec_entry_t  head_s;
  logic        push_s;
  logic        pop_s;

  rv_op_mapper u_mapper (
    .opcode_i  (in_instr[6:0]),
    .funct3_i  (in_instr[14:12]),
    .funct7_i  (in_instr[31:25]),
    .op_o      (map_op_s),
    .f3_o      (map_f3_s),
    .illegal_o (map_ill_s)
  );

  assign in_entry_s = make_entry(map_op_s, map_f3_s, in_instr, map_ill_s);
  assign head_s     = mem_q[rd_ptr_q];

  // Handshakes are gated by reset so nothing is offered or accepted while it is held
  assign in_ready  = !rst && (count_q < DEPTH_C) && !flush;
  assign out_valid = !rst && (count_q != {CNT_W{1'b0}});
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  assign out_op      = out_valid ? head_s.op      : 7'd0;
  assign out_f3      = out_valid ? head_s.f3      : 3'd0;
  assign out_instr   = out_valid ? head_s.instr   : 32'd0;
  assign out_illegal = out_valid ? head_s.illegal : 1'b0;
  assign illegal_cnt = ill_cnt_q;

  // Next-state for pointers, occupancy and the illegal counter; flush wins over push/pop
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    if (push_s && in_entry_s.illegal && (ill_cnt_q != 8'hFF)) begin
      ill_cnt_d = ill_cnt_q + 8'd1;
    end else begin
      ill_cnt_d = ill_cnt_q;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      ill_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  // Entry storage needs no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_entry_s;
    end
  end

endmodule

// File: tb/tb_inst_predecoder.sv
// Scoreboard bench for inst_predecoder: expected decoded entries are queued
// on accepted pushes and compared against the head when it is consumed.
module tb_inst_predecoder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [6:0]  out_op;
  logic [2:0]  out_f3;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic [7:0]  illegal_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [42:0] sb [$];
  int          exp_ill = 0;

  logic [31:0] tbl [24] = '{
    32'h00A00093, 32'h40208033, 32'h00208033, 32'h0020F033,
    32'h0020E033, 32'h0020A033, 32'h0020C033, 32'h00209033,
    32'h4020F033, 32'h0000A083, 32'h0040C093, 32'h0040E093,
    32'h0040A093, 32'h000080E7, 32'h0010A023, 32'h0000006F,
    32'h00209063, 32'h0020C063, 32'h0020D063, 32'h123450B7,
    32'h00008083, 32'h00209013, 32'h00000013, 32'h0020E063
  };

  inst_predecoder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_f3      (out_f3),
    .out_instr   (out_instr),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  // Reference decode written straight from the opcode table: {op, f3, instr, illegal}
  function automatic logic [42:0] model(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [6:0] op;
    logic [2:0] fo;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    op  = 7'h7F;
    fo  = 3'b000;
    if (opc == 7'b0110011) begin
      if (f7 == 7'b0000000 && f3 == 3'b000) begin op = 7'd0; fo = 3'b000; end
      if (f7 == 7'b0100000 && f3 == 3'b000) begin op = 7'd0; fo = 3'b001; end
      if (f7 == 7'b0000000 && f3 == 3'b111) begin op = 7'd0; fo = 3'b010; end
      if (f7 == 7'b0000000 && f3 == 3'b110) begin op = 7'd0; fo = 3'b011; end
      if (f7 == 7'b0000000 && f3 == 3'b010) begin op = 7'd0; fo = 3'b100; end
      if (f7 == 7'b0000000 && f3 == 3'b100) begin op = 7'd0; fo = 3'b101; end
    end
    if (opc == 7'b0000011 && f3 == 3'b010) begin op = 7'd1; fo = f3; end
    if (opc == 7'b0010011 && f3 == 3'b000) begin op = 7'd2; fo = f3; end
    if (opc == 7'b0010011 && f3 == 3'b100) begin op = 7'd3; fo = f3; end
    if (opc == 7'b0010011 && f3 == 3'b110) begin op = 7'd4; fo = f3; end
    if (opc == 7'b0010011 && f3 == 3'b010) begin op = 7'd5; fo = f3; end
    if (opc == 7'b1100111) begin op = 7'd6; fo = f3; end
    if (opc == 7'b0100011 && f3 == 3'b010) begin op = 7'd7; fo = f3; end
    if (opc == 7'b1101111) begin op = 7'd8; fo = f3; end
    if (opc == 7'b1100011 && f3 == 3'b000) begin op = 7'd9;  fo = f3; end
    if (opc == 7'b1100011 && f3 == 3'b001) begin op = 7'd10; fo = f3; end
    if (opc == 7'b1100011 && f3 == 3'b100) begin op = 7'd11; fo = f3; end
    if (opc == 7'b1100011 && f3 == 3'b101) begin op = 7'd12; fo = f3; end
    if (opc == 7'b0110111) begin op = 7'd13; fo = f3; end
    return {op, fo, w, (op == 7'h7F)};
  endfunction

  // One clock of stimulus; checks handshake outputs and the head against the scoreboard
  task automatic drive_cycle(input logic v, input logic [31:0] w, input logic rdy,
                             input logic fl, output logic acc);
    logic        exp_rdy;
    logic        exp_val;
    logic [42:0] got;
    logic [42:0] want;
    logic [42:0] dropped;
    in_valid  = v;
    in_instr  = w;
    out_ready = rdy;
    flush     = fl;
    #1;
    exp_rdy = !rst && (sb.size() < DEPTH) && !fl;
    exp_val = !rst && (sb.size() != 0);
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
    end
    checks++;
    if (out_valid !== exp_val) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_val, $time);
    end
    checks++;
    if (illegal_cnt !== exp_ill[7:0]) begin
      errors++;
      $display("FAIL illegal_cnt: got %0d expected %0d at %0t", illegal_cnt, exp_ill, $time);
    end
    got  = {out_op, out_f3, out_instr, out_illegal};
    want = exp_val ? sb[0] : 43'd0;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL head: got %h expected %h at %0t", got, want, $time);
    end
    acc = 1'b0;
    if (rst) begin
      sb.delete();
      exp_ill = 0;
    end else if (fl) begin
      sb.delete();
    end else begin
      if (exp_val && rdy) dropped = sb.pop_front();
      if (v && exp_rdy) begin
        acc  = 1'b1;
        want = model(w);
        sb.push_back(want);
        if (want[0] && exp_ill < 255) exp_ill++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic a;
    rst = 1'b1;
    drive_cycle(1'b1, 32'h00A00093, 1'b0, 1'b0, a);
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b0, a);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: got valid=%b ready=%b expected 0/0", out_valid, in_ready);
    end
    checks++;
    if (illegal_cnt !== 8'd0 || out_op !== 7'd0) begin
      errors++;
      $display("FAIL reset_vals: got cnt=%0d op=%0d expected 0/0", illegal_cnt, out_op);
    end
    rst = 1'b0;
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b0, a);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_addi();
    logic a;
    drive_cycle(1'b1, 32'h00A00093, 1'b0, 1'b0, a);
    checks++;
    if (out_valid !== 1'b1 || out_op !== 7'd2 || out_f3 !== 3'b000) begin
      errors++;
      $display("FAIL addi_latency: got v=%b op=%0d f3=%b expected 1/2/000", out_valid, out_op, out_f3);
    end
    drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, a);
  endtask

  task automatic test_full_order();
    logic a;
    drive_cycle(1'b1, 32'h40208033, 1'b0, 1'b0, a);
    drive_cycle(1'b1, 32'h00208063, 1'b0, 1'b0, a);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b expected 0", in_ready);
    end
    checks++;
    if (out_op !== 7'd0 || out_f3 !== 3'b001) begin
      errors++;
      $display("FAIL sub_head: got op=%0d f3=%b expected 0/001", out_op, out_f3);
    end
    drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, a);
    checks++;
    if (out_op !== 7'd9) begin
      errors++;
      $display("FAIL beq_head: got op=%0d expected 9", out_op);
    end
    drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, a);
  endtask

  task automatic test_illegal_sat();
    logic a;
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, a);
      if (i > 0) begin
        checks++;
        if (out_illegal !== 1'b1 || out_op !== 7'h7F) begin
          errors++;
          $display("FAIL illegal_head: got ill=%b op=%h expected 1/7f", out_illegal, out_op);
        end
      end
    end
    checks++;
    if (illegal_cnt !== 8'd255) begin
      errors++;
      $display("FAIL illegal_sat: got %0d expected 255", illegal_cnt);
    end
    drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, a);
  endtask

  task automatic test_flush();
    logic a;
    logic [7:0] cnt_before;
    drive_cycle(1'b1, 32'h00A00093, 1'b0, 1'b0, a);
    drive_cycle(1'b1, 32'h123450B7, 1'b0, 1'b0, a);
    cnt_before = illegal_cnt;
    drive_cycle(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, a);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got %b expected 0", out_valid);
    end
    drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, a);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_cnt !== cnt_before) begin
      errors++;
      $display("FAIL flush_empty: got v=%b r=%b cnt=%0d expected 0/1/%0d",
               out_valid, in_ready, illegal_cnt, cnt_before);
    end
  endtask

  task automatic test_back_to_back();
    logic a;
    drive_cycle(1'b1, tbl[0], 1'b0, 1'b0, a);
    for (int i = 1; i <= 10; i++) begin
      drive_cycle(1'b1, tbl[i], 1'b1, 1'b0, a);
      checks++;
      if (out_valid !== 1'b1 || a !== 1'b1) begin
        errors++;
        $display("FAIL b2b_valid: got v=%b acc=%b expected 1/1 step %0d", out_valid, a, i);
      end
    end
    drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, a);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_mapping();
    logic a;
    int   idx;
    idx = 0;
    for (int n = 0; n < 200 && idx < 24; n++) begin
      drive_cycle(1'b1, tbl[idx], 1'($urandom_range(0, 1)), 1'b0, a);
      if (a) idx++;
    end
    checks++;
    if (idx != 24) begin
      errors++;
      $display("FAIL mapping_timeout: got %0d pushes expected 24", idx);
    end
    for (int n = 0; n < 4; n++) drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, a);
  endtask

  task automatic test_reset_mid();
    logic a;
    rst = 1'b1;
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b0, a);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, a);
    drive_cycle(1'b1, 32'h00A00093, 1'b0, 1'b0, a);
    checks++;
    if (in_ready !== 1'b0 || illegal_cnt !== 8'd5) begin
      errors++;
      $display("FAIL pre_reset: got r=%b cnt=%0d expected 0/5", in_ready, illegal_cnt);
    end
    rst = 1'b1;
    drive_cycle(1'b1, 32'h00A00093, 1'b1, 1'b0, a);
    checks++;
    if (out_valid !== 1'b0 || illegal_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b cnt=%0d expected 0/0", out_valid, illegal_cnt);
    end
    rst = 1'b0;
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b0, a);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got r=%b v=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_addi();
    test_full_order();
    test_illegal_sat();
    test_flush();
    test_back_to_back();
    test_mapping();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
